// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution datapath.
// Saturation is selected by MAC_UNIT_SAT_EN; the default build wraps.
package conv_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned FRAC_BITS  = 0;
    localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 1;

    typedef logic signed [DATA_WIDTH-1:0] data_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;

    localparam data_t SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam data_t SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/sat_narrow.sv
// Combinational narrower from a 2*W+1 bit accumulator to a W bit word.
// MAC_UNIT_SAT_EN defined: clamp to the signed range; undefined: keep the low W bits.
module sat_narrow
    import conv_pkg::*;
#(
    parameter int unsigned W = DATA_WIDTH
) (
    input  logic signed [2*W:0] acc_i,
    output logic signed [W-1:0] narrow_c
);

`ifdef MAC_UNIT_SAT_EN
    localparam logic signed [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

    // The value fits iff every bit above the result sign bit repeats it.
    logic fits_c;

    always_comb begin
        fits_c = (acc_i[2*W:W-1] == {(W+2){1'b0}}) ||
                 (acc_i[2*W:W-1] == {(W+2){1'b1}});
        if (fits_c) begin
            narrow_c = acc_i[W-1:0];
        end else if (acc_i[2*W]) begin
            narrow_c = MIN_W;
        end else begin
            narrow_c = MAX_W;
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^acc_i[2*W:W];
    assign narrow_c  = acc_i[W-1:0];
`endif

endmodule

// File: rtl/mac_unit.sv
// Registered multiply-accumulate cell: result <= narrow((data*weight >>> FRAC_BITS) + bias).
// Narrowing saturates when MAC_UNIT_SAT_EN is defined, otherwise wraps.
module mac_unit
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = conv_pkg::DATA_WIDTH,
    parameter int unsigned FRAC_BITS  = conv_pkg::FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic signed [DATA_WIDTH-1:0] weight_i,
    input  logic signed [DATA_WIDTH-1:0] bias_i,
    output logic signed [DATA_WIDTH-1:0] result
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned AW = 2 * DATA_WIDTH + 1;

    logic signed [PW-1:0]         prod_c;
    logic signed [PW-1:0]         scaled_c;
    logic signed [AW-1:0]         sum_c;
    logic signed [DATA_WIDTH-1:0] narrow_c;

    // Full-precision product, fixed-point rescale (floor), then bias add one bit wider.
    always_comb begin
        prod_c   = PW'(data_i) * PW'(weight_i);
        scaled_c = prod_c >>> FRAC_BITS;
        sum_c    = {scaled_c[PW-1], scaled_c} +
                   {{(DATA_WIDTH+1){bias_i[DATA_WIDTH-1]}}, bias_i};
    end

    sat_narrow #(
        .W        (DATA_WIDTH)
    ) u_sat_narrow (
        .acc_i    (sum_c),
        .narrow_c (narrow_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
        end else if (en) begin
            result <= narrow_c;
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed cases plus randomized traffic against a reference model.
module tb_mac_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] data_i;
    logic [15:0] weight_i;
    logic [15:0] bias_i;
    logic [15:0] result0;
    logic [15:0] result8;

    int checks;
    int failures;

    logic [15:0] exp0;
    logic [15:0] exp8;

    mac_unit #(.DATA_WIDTH(16), .FRAC_BITS(0)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_i   (data_i),
        .weight_i (weight_i),
        .bias_i   (bias_i),
        .result   (result0)
    );

    mac_unit #(.DATA_WIDTH(16), .FRAC_BITS(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data_i   (data_i),
        .weight_i (weight_i),
        .bias_i   (bias_i),
        .result   (result8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical definition.
    function automatic logic [15:0] mac_ref(input logic [15:0] d, input logic [15:0] w,
                                            input logic [15:0] b, input int frac);
        longint p;
        longint s;
        p = longint'($signed(d)) * longint'($signed(w));
        s = (p >>> frac) + longint'($signed(b));
`ifdef MAC_UNIT_SAT_EN
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [15:0] d, input logic [15:0] w,
                         input logic [15:0] b);
        en       = e;
        data_i   = d;
        weight_i = w;
        bias_i   = b;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 16'h0);
        #13;
        check("reset_r0", result0, 16'h0000);
        check("reset_r8", result8, 16'h0000);
        step();
        rst = 1'b1;
        step();
        check("post_release", result0, 16'h0000);

        drive(1'b1, 16'd3, 16'd4, 16'd5);
        #1;
        check("basic_before_edge", result0, 16'h0000);
        step();
        check("basic", result0, 16'h0011);

        drive(1'b1, 16'hFFFE, 16'd7, 16'd1);
        step();
        check("signed", result0, 16'hFFF3);

        drive(1'b1, 16'h7FFF, 16'd2, 16'd0);
        step();
`ifdef MAC_UNIT_SAT_EN
        check("ovf_pos", result0, 16'h7FFF);
`else
        check("ovf_pos", result0, 16'hFFFE);
`endif

        drive(1'b1, 16'h8000, 16'd2, 16'd0);
        step();
`ifdef MAC_UNIT_SAT_EN
        check("ovf_neg", result0, 16'h8000);
`else
        check("ovf_neg", result0, 16'h0000);
`endif

        drive(1'b1, 16'h0180, 16'h0200, 16'h0100);
        step();
        check("fixed_point", result8, 16'h0400);

        drive(1'b1, 16'd3, 16'd4, 16'd5);
        step();
        check("hold_load", result0, 16'h0011);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(1'b0, 16'hxxxx, 16'hxxxx, 16'hxxxx);
            else drive(1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
            step();
            check("hold", result0, 16'h0011);
        end
        drive(1'b1, 16'd10, 16'hFFFD, 16'd100);
        #1;
        check("hold_release_before", result0, 16'h0011);
        step();
        check("hold_release", result0, 16'd70);

        drive(1'b1, 16'd3, 16'd4, 16'd5);
        step();
        check("areset_pre", result0, 16'h0011);
        #2;
        rst = 1'b0;
        #1;
        check("areset_immediate", result0, 16'h0000);
        step();
        check("areset_low", result0, 16'h0000);
        #3;
        en  = 1'b0;
        rst = 1'b1;
        step();
        check("areset_released_idle", result0, 16'h0000);
        en = 1'b1;
        step();
        check("areset_first_load", result0, 16'h0011);

        exp0 = result0;
        exp8 = result8;
        exp0 = 16'h0011;
        exp8 = mac_ref(16'd3, 16'd4, 16'd5, 8);
        for (int i = 0; i < 300; i++) begin
            logic [15:0] d;
            logic [15:0] w;
            logic [15:0] b;
            logic        e;
            e = 1'($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            w = (i % 4 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            b = 16'($urandom);
            drive(e, d, w, b);
            if (e) begin
                exp0 = mac_ref(d, w, b, 0);
                exp8 = mac_ref(d, w, b, 8);
            end
            step();
            check("rand_f0", result0, exp0);
            check("rand_f8", result8, exp8);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
